// File: rtl/multi_event_waiter.sv
// multi_event_waiter: arms on request, waits for any/all masked event pulses, reports via valid/ready.
// Optional EVWAIT_TIMEOUT_EN adds timeout_cycles/fire_timeout and a bounded wait.
module multi_event_waiter #(
  parameter int N_EVENTS = 3,
  parameter int ID_W     = $clog2(N_EVENTS > 1 ? N_EVENTS : 2),
  parameter int DROP_W   = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                arm,
  input  logic [N_EVENTS-1:0] arm_mask,
  input  logic                arm_all,
  input  logic [N_EVENTS-1:0] ev_in,
  output logic                fire_valid,
  input  logic                fire_ready,
  output logic [N_EVENTS-1:0] fire_vec,
  output logic [ID_W-1:0]     fire_id,
  output logic                busy,
  output logic                arm_err,
`ifdef EVWAIT_TIMEOUT_EN
  input  logic [15:0]         timeout_cycles,
  output logic                fire_timeout,
`endif
  output logic [DROP_W-1:0]   drop_cnt
);
  typedef enum logic [1:0] {IDLE, ARMED, FIRED} state_t;
  state_t state;
  logic [N_EVENTS-1:0] mask, captured, cap_nx;
  logic all_mode, cond, arm_ok, tmo;
  function automatic logic [ID_W-1:0] lowest(input logic [N_EVENTS-1:0] v);
    lowest = '0;
    for (int i = N_EVENTS - 1; i >= 0; i--)
      if (v[i]) lowest = ID_W'(i);
  endfunction
  assign cap_nx = captured | (ev_in & mask);
  assign cond   = all_mode ? &(cap_nx | ~mask) : |cap_nx;
  assign arm_ok = arm && |arm_mask;
`ifdef EVWAIT_TIMEOUT_EN
  logic [15:0] tcnt;
  assign tmo = timeout_cycles != 16'd0 && tcnt + 16'd1 == timeout_cycles;
`else
  assign tmo = 1'b0;
`endif
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      mask       <= '0;
      all_mode   <= 1'b0;
      captured   <= '0;
      fire_valid <= 1'b0;
      fire_vec   <= '0;
      fire_id    <= '0;
      busy       <= 1'b0;
      arm_err    <= 1'b0;
      drop_cnt   <= '0;
`ifdef EVWAIT_TIMEOUT_EN
      tcnt         <= '0;
      fire_timeout <= 1'b0;
`endif
    end else begin
      arm_err <= 1'b0;
      if (|ev_in && state != ARMED && drop_cnt != '1) drop_cnt <= drop_cnt + 1'b1;
`ifdef EVWAIT_TIMEOUT_EN
      if (state == ARMED) tcnt <= tcnt + 16'd1;
      if (arm_ok && (state != FIRED || fire_ready)) tcnt <= '0;
`endif
      case (state)
        IDLE: begin
          if (arm_ok) begin
            state    <= ARMED;
            busy     <= 1'b1;
            mask     <= arm_mask;
            all_mode <= arm_all;
            captured <= '0;
          end else if (arm) arm_err <= 1'b1;
        end
        ARMED: begin
          if (arm_ok) begin
            mask     <= arm_mask;
            all_mode <= arm_all;
            captured <= '0;
          end else begin
            if (arm) arm_err <= 1'b1;
            captured <= cap_nx;
            if (cond || tmo) begin
              state      <= FIRED;
              fire_valid <= 1'b1;
              fire_vec   <= cond ? cap_nx : captured;
              fire_id    <= lowest(cond ? cap_nx : captured);
`ifdef EVWAIT_TIMEOUT_EN
              fire_timeout <= !cond;
`endif
            end
          end
        end
        FIRED: begin
          if (fire_ready) begin
            fire_valid <= 1'b0;
            fire_vec   <= '0;
            fire_id    <= '0;
`ifdef EVWAIT_TIMEOUT_EN
            fire_timeout <= 1'b0;
`endif
            state <= arm_ok ? ARMED : IDLE;
            busy  <= arm_ok;
            if (arm_ok) begin
              mask     <= arm_mask;
              all_mode <= arm_all;
              captured <= '0;
            end else if (arm) arm_err <= 1'b1;
          end else if (arm) arm_err <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
